// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings and the multiply sequencer state type.
// Pure declarations: no latency, no flow control.
// Imported by the ALU and by the multiply sequencer.
package alu_pkg;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_SUB = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_OR  = 4'b0011;
    localparam logic [3:0] ALU_XOR = 4'b0100;
    localparam logic [3:0] ALU_SLT = 4'b0101;
    localparam logic [3:0] ALU_EQ  = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu.sv
// Shared execute-stage ALU.
// Latency: combinational, zero cycles.
// Backpressure: none; result follows operands every cycle.
module alu
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4
) (
    input  logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    src_a,
    input  logic [DATA_WIDTH-1:0]    src_b,
    output logic [DATA_WIDTH-1:0]    alu_result
);

    logic [3:0] op4;

    always_comb begin
        op4        = 4'(alu_operation);
        alu_result = '0;
        case (op4)
            ALU_AND: alu_result = src_a & src_b;
            ALU_SUB: alu_result = src_a - src_b;
            ALU_ADD: alu_result = src_a + src_b;
            ALU_OR:  alu_result = src_a | src_b;
            ALU_XOR: alu_result = src_a ^ src_b;
            ALU_SLT: alu_result = {{(DATA_WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            ALU_EQ:  alu_result = {{(DATA_WIDTH-1){1'b0}}, (src_a == src_b)};
            default: alu_result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier (low half of a*b) driving the shared ALU in ADD mode.
// Latency: k busy cycles (k = msb index of op_b + 1, min 1; or DATA_WIDTH without early exit), then a done pulse.
// Backpressure: stalls the pipeline via busy; start while busy is dropped.
module alu_mul_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 4,
    parameter int EARLY_EXIT    = 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [DATA_WIDTH-1:0]    op_a,
    input  logic [DATA_WIDTH-1:0]    op_b,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_WIDTH-1:0]    product,
    output logic                     alu_req,
    output logic [DATA_WIDTH-1:0]    alu_src_a,
    output logic [DATA_WIDTH-1:0]    alu_src_b,
    output logic [OPCODE_LENGTH-1:0] alu_operation,
    input  logic [DATA_WIDTH-1:0]    alu_result
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    mul_state_t            state_q, state_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] product_q, product_d;
    logic                  last_iter;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    // Stop after the final bit position, or early once no set multiplier bits remain.
    assign last_iter = (count_q == CNT_W'(DATA_WIDTH - 1)) ||
                       ((EARLY_EXIT != 0) && ((mplier_q >> 1) == '0));

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    state_d  = BUSY;
                    acc_d    = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    count_d  = '0;
                end
            end
            BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = alu_result;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CNT_W'(1);
                if (last_iter) begin
                    state_d   = DONE;
                    product_d = acc_d;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy          = (state_q == BUSY);
    assign done          = (state_q == DONE);
    assign alu_req       = busy;
    assign alu_src_a     = acc_q;
    assign alu_src_b     = mcand_q;
    assign alu_operation = busy ? OPCODE_LENGTH'(ALU_ADD) : OPCODE_LENGTH'(ALU_AND);
    assign product       = product_q;

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Directed bench: one sequencer with early exit and one without, each wired to its own ALU.
module tb_alu_mul_sequencer;

    logic        clk;
    logic        reset;
    logic        start_e, start_f;
    logic [31:0] op_a, op_b;

    logic        busy_e, done_e, req_e;
    logic [31:0] prod_e, sa_e, sb_e, res_e;
    logic [3:0]  opc_e;
    logic        busy_f, done_f, req_f;
    logic [31:0] prod_f, sa_f, sb_f, res_f;
    logic [3:0]  opc_f;

    int n_cmp = 0;
    int n_err = 0;

    alu_mul_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .EARLY_EXIT(1)) dut_e (
        .clk(clk), .reset(reset), .start(start_e), .op_a(op_a), .op_b(op_b),
        .busy(busy_e), .done(done_e), .product(prod_e), .alu_req(req_e),
        .alu_src_a(sa_e), .alu_src_b(sb_e), .alu_operation(opc_e), .alu_result(res_e)
    );
    alu #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) alu_e (
        .alu_operation(opc_e), .src_a(sa_e), .src_b(sb_e), .alu_result(res_e)
    );

    alu_mul_sequencer #(.DATA_WIDTH(32), .OPCODE_LENGTH(4), .EARLY_EXIT(0)) dut_f (
        .clk(clk), .reset(reset), .start(start_f), .op_a(op_a), .op_b(op_b),
        .busy(busy_f), .done(done_f), .product(prod_f), .alu_req(req_f),
        .alu_src_a(sa_f), .alu_src_b(sb_f), .alu_operation(opc_f), .alu_result(res_f)
    );
    alu #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) alu_f (
        .alu_operation(opc_f), .src_a(sa_f), .src_b(sb_f), .alu_result(res_f)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Launch one multiply and follow it to its done pulse; all sampling on negedge.
    task automatic run_mul(input bit full, input logic [31:0] a, input logic [31:0] b,
                           input int exp_k, input logic [31:0] exp_p, input string tag);
        int k;
        @(negedge clk);
        op_a = a;
        op_b = b;
        if (full) start_f = 1'b1; else start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        start_f = 1'b0;
        chk({tag, " opc"}, 32'(full ? opc_f : opc_e), 32'h2);
        chk({tag, " req"}, 32'(full ? req_f : req_e), 32'h1);
        k = 0;
        while ((full ? busy_f : busy_e) && k < 40) begin
            k++;
            @(negedge clk);
        end
        chk({tag, " busy cycles"}, 32'(k), 32'(exp_k));
        chk({tag, " done"}, 32'(full ? done_f : done_e), 32'h1);
        chk({tag, " product"}, full ? prod_f : prod_e, exp_p);
        @(negedge clk);
        chk({tag, " done drop"}, 32'(full ? done_f : done_e), 32'h0);
        chk({tag, " opc idle"}, 32'(full ? opc_f : opc_e), 32'h0);
        chk({tag, " product held"}, full ? prod_f : prod_e, exp_p);
    endtask

    initial begin
        int nb;
        int nd;
        reset   = 1'b1;
        start_e = 1'b0;
        start_f = 1'b0;
        op_a    = '0;
        op_b    = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst busy", 32'(busy_e), 32'h0);
        chk("rst done", 32'(done_e), 32'h0);
        chk("rst req", 32'(req_e), 32'h0);
        chk("rst opc", 32'(opc_e), 32'h0);
        chk("rst product", prod_e, 32'h0);
        chk("rst busy full", 32'(busy_f), 32'h0);
        reset = 1'b0;

        run_mul(1'b0, 32'd6, 32'd7, 3, 32'd42, "basic");
        run_mul(1'b0, 32'h12345678, 32'h0, 1, 32'h0, "zero ee");
        run_mul(1'b1, 32'h12345678, 32'h0, 32, 32'h0, "zero full");
        run_mul(1'b0, 32'hFFFFFFFD, 32'hFFFFFFFB, 32, 32'h0000000F, "neg ee");
        run_mul(1'b1, 32'hFFFFFFFD, 32'hFFFFFFFB, 32, 32'h0000000F, "neg full");
        run_mul(1'b0, 32'hFFFFFFFF, 32'h2, 2, 32'hFFFFFFFE, "wrap");
        run_mul(1'b1, 32'd6, 32'd7, 32, 32'd42, "basic full");

        // Start pulsed mid-run must not restart the sequence.
        @(negedge clk);
        op_a = 32'd3;
        op_b = 32'h80000000;
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        nb = 0;
        nd = 0;
        for (int cyc = 1; cyc <= 32; cyc++) begin
            if (busy_e) nb++;
            if (done_e) nd++;
            if (cyc == 5) begin
                op_a = 32'd9;
                op_b = 32'd9;
                start_e = 1'b1;
            end else begin
                start_e = 1'b0;
            end
            @(negedge clk);
        end
        chk("ign busy cycles", 32'(nb), 32'd32);
        chk("ign early done", 32'(nd), 32'd0);
        chk("ign done", 32'(done_e), 32'h1);
        chk("ign product", prod_e, 32'h80000000);

        // Back-to-back start in the done cycle.
        op_a = 32'd5;
        op_b = 32'd5;
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        chk("b2b busy", 32'(busy_e), 32'h1);
        chk("b2b product hold", prod_e, 32'h80000000);
        repeat (2) @(negedge clk);
        chk("b2b busy last", 32'(busy_e), 32'h1);
        chk("b2b product hold last", prod_e, 32'h80000000);
        @(negedge clk);
        chk("b2b done", 32'(done_e), 32'h1);
        chk("b2b product", prod_e, 32'd25);

        // Reset in the fourth busy cycle aborts without a done pulse.
        @(negedge clk);
        op_a = 32'd10;
        op_b = 32'hFF;
        start_e = 1'b1;
        @(negedge clk);
        start_e = 1'b0;
        repeat (3) @(negedge clk);
        chk("abort busy before", 32'(busy_e), 32'h1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(busy_e), 32'h0);
        chk("abort done", 32'(done_e), 32'h0);
        chk("abort product", prod_e, 32'h0);
        nd = 0;
        for (int i = 0; i < 10; i++) begin
            if (done_e) nd++;
            @(negedge clk);
        end
        chk("abort no done", 32'(nd), 32'd0);
        run_mul(1'b0, 32'd10, 32'd3, 2, 32'd30, "after abort");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/alu_mul_sequencer.md
Name: alu_mul_sequencer

Overview:
- Multi-cycle shift-and-add multiplier controller.
- Reuses the core's shared 32-bit ALU in ADD mode to produce the low DATA_WIDTH bits of a*b, i.e. RISC-V MUL semantics.
- Sits beside the ALU in the execute stage. While busy it drives the ALU operand/opcode mux and holds the pipeline stalled.
- One iteration per cycle, with optional early exit once the remaining multiplier bits are zero.

Parameters:
- DATA_WIDTH, 32, operand/product width.
- OPCODE_LENGTH, 4, ALU operation field width.
- EARLY_EXIT, 1, when 1 the sequence terminates as soon as the remaining multiplier is zero; when 0 it always runs DATA_WIDTH iterations.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  request pulse; accepted in IDLE or DONE only.
- op_a  in  DATA_WIDTH  multiplicand, sampled when start is accepted.
- op_b  in  DATA_WIDTH  multiplier, sampled when start is accepted.
- busy  out  1  high in BUSY; core uses it as the stall request.
- done  out  1  one-cycle pulse; product is valid.
- product  out  DATA_WIDTH  low DATA_WIDTH bits of op_a*op_b, held until the next accepted start.
- alu_req  out  1  high in BUSY; selects this block's operands into the shared ALU.
- alu_src_a  out  DATA_WIDTH  accumulator register.
- alu_src_b  out  DATA_WIDTH  shifted multiplicand register.
- alu_operation  out  OPCODE_LENGTH  4'b0010 (ADD) while alu_req=1, else 4'b0000.
- alu_result  in  DATA_WIDTH  shared ALU output, combinational from alu_src_a/alu_src_b.

Behaviour:
- Reset: state=IDLE; acc, mcand, mplier, count and product cleared to 0; busy=done=alu_req=0. Reset in any state, including mid-BUSY, aborts the operation with no done pulse.
- States:
  - IDLE -> BUSY on start.
  - BUSY -> BUSY while iterating.
  - BUSY -> DONE on the terminate condition.
  - DONE -> BUSY on start.
  - DONE -> IDLE otherwise.
- Accept (start in IDLE/DONE): acc<=0, mcand<=op_a, mplier<=op_b, count<=0.
- start in BUSY is ignored: no restart, no queuing.
- BUSY, each cycle:
  - if mplier[0], acc<=alu_result (acc+mcand, wrapping mod 2^DATA_WIDTH); else acc holds.
  - mcand<=mcand<<1, mplier<=mplier>>1, count<=count+1.
- Terminate when count==DATA_WIDTH-1, or when EARLY_EXIT=1 and (mplier>>1)==0.
  - The final iteration still applies its add.
  - On terminate, product<=final acc value, including that last add.
- Latency: start accepted at edge 0; BUSY occupies cycles 1..k; done=1 in cycle k+1.
  - k = max(1, index of highest set bit of op_b + 1) with EARLY_EXIT=1.
  - k = DATA_WIDTH with EARLY_EXIT=0.
  - op_b=0 gives k=1 and product=0.
- Signedness: none needed; low-half product is identical for signed and unsigned operands.
- The ALU is combinational, so the add result is registered in the same cycle it is requested. There is no ALU latency.
- busy/alu_req are decoded from the state register (no glitches from start).
- product changes only on the terminate edge or on reset.
- count width is clog2(DATA_WIDTH).

Decomposition:
- Shared package alu_pkg holds:
  - ALU opcode localparams: ALU_AND=0000, ALU_SUB=0001, ALU_ADD=0010, ALU_OR=0011, ALU_XOR=0100, ALU_SLT=0101, ALU_EQ=1000.
  - The mul_state_t enum {IDLE, BUSY, DONE}.
- No sub-module. The ALU itself is external; the bench instantiates the real alu and wires alu_src_a/alu_src_b/alu_operation/alu_result to it.

Test Plan:
- Basic: reset, then start with a=6, b=7 -> busy cycles 1-3, done pulse in cycle 4, product=42, alu_operation=0010 during busy.
- Zero multiplier: a=0x12345678, b=0 -> exactly 1 busy cycle, done in cycle 2, product=0. Same with EARLY_EXIT=0 -> 32 busy cycles, product=0.
- Wrap/signed: a=0xFFFFFFFD (-3), b=0xFFFFFFFB (-5) -> 32 busy cycles, product=0x0000000F. a=0xFFFFFFFF, b=2 -> 2 busy cycles, product=0xFFFFFFFE.
- Ignored start: a=3, b=0x80000000 accepted; pulse start with a=9, b=9 in cycle 5 -> run continues, done in cycle 33, product=0x80000000.
- Back-to-back: start asserted in the done cycle with a=5, b=5 -> BUSY next cycle, product stays 0x80000000 until the new done, then 25.
- Reset mid-op: a=10, b=0xFF, reset in busy cycle 4 -> next cycle IDLE, busy=0, product=0, no done pulse; a following start with a=10, b=3 -> product=30.
